// File: rtl/fifo_read_drain_if.sv
// FIFO read port and downstream valid/ready stream as seen by the drain controller.
interface fifo_read_drain_if #(
  parameter int WIDTH = 16
);
  logic             rd_en;
  logic             empty;
  logic             underflow;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output rd_en, m_data, m_valid,
    input  empty, underflow, data_out, m_ready
  );

  modport slave (
    input  rd_en, m_data, m_valid,
    output empty, underflow, data_out, m_ready
  );
endinterface

// File: rtl/fifo_read_drain.sv
// Read-side drain for the sync FIFO: issues rd_en against empty, captures the
// one-cycle-late read data in a small ring buffer and presents it as valid/ready.
//
// state | meaning
// IDLE  | drain disabled, nothing in flight or buffered
// RUN   | drain enabled, FIFO reads permitted
// STOP  | drain disabled, finishing the in-flight word and buffered words
module fifo_read_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain_en,
  fifo_read_drain_if.master bus,
  output logic              busy,
  output logic [15:0]       word_count,
  output logic              err_underflow
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state;
  state_t                state_next;
  logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [OCC_W-1:0]      occ;
  logic                  inflight;
  logic                  room;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Room counts the in-flight word so a full buffer never loses a capture;
  // only registered state and FIFO flags feed rd_en, never m_ready.
  assign room        = (occ + OCC_W'(inflight)) < OCC_W'(BUF_DEPTH);
  assign bus.rd_en   = rst_n && drain_en && !bus.empty && room;
  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = mem[head];
  assign pop         = bus.m_valid && bus.m_ready;
  assign busy        = bus.m_valid || inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head          <= '0;
      tail          <= '0;
      occ           <= '0;
      inflight      <= 1'b0;
      word_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= bus.rd_en;
      if (inflight) begin
        mem[tail] <= bus.data_out;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        head       <= ptr_inc(head);
        word_count <= word_count + 16'd1;
      end
      occ <= occ + OCC_W'(inflight) - OCC_W'(pop);
      if (bus.underflow) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (drain_en) state_next = RUN;
      RUN:     if (!drain_en) state_next = STOP;
      STOP: begin
        if (drain_en)  state_next = RUN;
        else if (!busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: behavioural FIFO plus an in-order scoreboard of owed words.
module tb_fifo_read_drain;
  localparam int W = 16;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_en = 1'b0;
  logic        busy;
  logic [15:0] word_count;
  logic        err_underflow;

  fifo_read_drain_if #(.WIDTH(W)) bus ();

  fifo_read_drain #(.FIFO_WIDTH(W), .BUF_DEPTH(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drain_en      (drain_en),
    .bus           (bus),
    .busy          (busy),
    .word_count    (word_count),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] fifo_q[$];     // contents of the upstream FIFO
  logic [15:0] exp_q[$];      // words read but not yet delivered, in order
  int          issue_edge[$]; // edge index at which each owed word was read
  int          rd_log[$];
  int          pop_log[$];
  int          edge_n = 0;
  int          delivered = 0;
  int          rd_pulses = 0;
  logic        err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_rd_en"}, bus.rd_en, 0);
    check_eq({tag, "_m_valid"}, bus.m_valid, 0);
    check_eq({tag, "_m_data"}, bus.m_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_word_count"}, word_count, 0);
    check_eq({tag, "_err_underflow"}, err_underflow, 0);
  endtask

  // One clock: called at posedge+1, checks outputs, advances the model across the edge.
  task automatic tick();
    int          avail;
    bit          exp_rd;
    bit          rd;
    bit          pop;
    bit          uf;
    logic [15:0] w;
    logic [15:0] dcount;
    w = '0;
    bus.empty = (fifo_q.size() == 0);
    #1;
    avail = 0;
    foreach (issue_edge[i]) if (issue_edge[i] <= edge_n - 1) avail++;
    exp_rd = drain_en && !bus.empty && (issue_edge.size() < D);
    dcount = delivered[15:0];
    check_eq("rd_en", bus.rd_en, exp_rd);
    check_eq("m_valid", bus.m_valid, avail > 0);
    if (avail > 0) check_eq("m_data", bus.m_data, exp_q[0]);
    check_eq("busy", busy, issue_edge.size() > 0);
    check_eq("word_count", word_count, dcount);
    check_eq("err_underflow", err_underflow, err_exp);
    rd  = exp_rd;
    pop = (avail > 0) && bus.m_ready;
    uf  = bus.underflow;
    @(posedge clk);
    edge_n++;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(issue_edge.pop_front());
      delivered++;
      pop_log.push_back(edge_n);
    end
    if (rd) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      issue_edge.push_back(edge_n);
      rd_pulses++;
      rd_log.push_back(edge_n);
    end
    if (uf) err_exp = 1'b1;
    #1;
    bus.data_out = rd ? w : 16'($urandom);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((fifo_q.size() > 0 || issue_edge.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, fifo_q.size() + issue_edge.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    drain_en      = 1'b0;
    bus.underflow = 1'b0;
    bus.m_ready   = 1'b0;
    exp_q.delete();
    issue_edge.delete();
    fifo_q.delete();
    rd_log.delete();
    pop_log.delete();
    delivered = 0;
    rd_pulses = 0;
    err_exp   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.empty     = 1'b1;
    bus.underflow = 1'b0;
    bus.data_out  = '0;
    bus.m_ready   = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      drain_en      = 1'($urandom);
      bus.empty     = 1'($urandom);
      bus.m_ready   = 1'($urandom);
      bus.underflow = 1'($urandom);
      bus.data_out  = 16'($urandom);
      #3;
      check_zero_outputs("rst_hold");
      @(posedge clk);
      #1;
    end
    do_reset();

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    run_until_idle("stream", 30);
    tick();
    check_eq("stream_words", word_count, 8);
    check_eq("stream_latency", pop_log[0] - rd_log[0], 2);
    check_eq("stream_span", pop_log[7] - pop_log[0], 7);
    check_eq("stream_busy", busy, 0);

    // Reset mid-burst
    do_reset();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("burst_started", word_count != 0, 1);
    do_reset();

    // Backpressure then toggling ready
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    drain_en = 1'b1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("bp_rd_pulses", rd_pulses, D);
    check_eq("bp_valid", bus.m_valid, 1);
    check_eq("bp_head", bus.m_data, 16'h0001);
    n = 0;
    while ((fifo_q.size() > 0 || issue_edge.size() > 0) && n < 60) begin
      bus.m_ready = ~bus.m_ready;
      tick();
      n++;
    end
    check_eq("bp_delivered", delivered, 8);
    check_eq("bp_fifo_empty", fifo_q.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drain_en    = ($urandom_range(0, 7) != 0);
      bus.m_ready = 1'($urandom);
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) fifo_q.push_back(16'($urandom));
      tick();
    end
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    run_until_idle("random", 40);

    // Stop mid-drain after the 4th read, then resume
    do_reset();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    n = 0;
    while (rd_pulses < 4 && n < 20) begin
      tick();
      n++;
    end
    drain_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("stop_rd_pulses", rd_pulses, 4);
    check_eq("stop_delivered", word_count, 4);
    check_eq("stop_busy", busy, 0);
    drain_en = 1'b1;
    run_until_idle("resume", 30);
    check_eq("resume_delivered", delivered, 8);

    // Sparse writes around empty, then underflow stickiness
    do_reset();
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fifo_q.push_back(16'($urandom));
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) tick();
    end
    run_until_idle("sparse", 20);
    check_eq("sparse_no_err", err_underflow, 0);
    bus.underflow = 1'b1;
    tick();
    bus.underflow = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("err_sticky", err_underflow, 1);
    do_reset();

    // word_count wrap
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    n = 0;
    while (delivered < 65537 && n < 66000) begin
      if (fifo_q.size() < 8) fifo_q.push_back(16'(n));
      tick();
      n++;
    end
    check_eq("wrap_delivered", delivered, 65537);
    check_eq("wrap_count", word_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_read_drain.md
# fifo_read_drain

Read-side controller for the team's synchronous FIFO (FIFO_WIDTH 16, FIFO_DEPTH 8). It issues `rd_en` against the FIFO's `empty` flag and absorbs the FIFO's one-cycle read latency in a small holding buffer. Captured words are presented downstream on a valid/ready stream at up to one word per clock, with no combinational path from `m_ready` to `rd_en`. It sits between the FIFO's read port and any consumer.

## Interface
Parameters:
- FIFO_WIDTH, 16, word width; must match the FIFO.
- BUF_DEPTH, 3, holding-buffer entries; minimum 3 for full throughput.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- drain_en  input  1  permits new FIFO reads while high.
- empty  input  1  FIFO empty flag.
- underflow  input  1  FIFO underflow flag.
- data_out  input  FIFO_WIDTH  FIFO read data.
- rd_en  output  1  FIFO read request.
- m_data  output  FIFO_WIDTH  downstream data, head of buffer.
- m_valid  output  1  downstream word valid.
- m_ready  input  1  downstream accept.
- busy  output  1  a word is in flight or buffered.
- word_count  output  16  words delivered downstream (m_valid && m_ready), wraps modulo 2^16.
- err_underflow  output  1  sticky; set when `underflow` is sampled high.

## Operation
- FIFO contract: when `rd_en && !empty` is sampled at edge N, the word appears on `data_out` after edge N and is stable through edge N+1. The FIFO never returns data when `empty` was sampled high.
- `inflight` is a 1-bit register, set at edge N when `rd_en && !empty` was sampled.
- `rd_en = drain_en && !empty && (occ + inflight < BUF_DEPTH)`. Registered-state terms only, so `m_ready` does not feed it.
- When `inflight` is high at an edge, `data_out` is written to the buffer tail.
- Buffer is a circular FIFO with occupancy `occ` (0..BUF_DEPTH). Head and tail pointers wrap at BUF_DEPTH.
- `m_valid = (occ != 0)`. `m_data` = head entry. A pop occurs when `m_valid && m_ready`.
- `occ_next = occ + inflight - pop`. Capture and pop in the same cycle leave `occ` unchanged.
- Holding `m_valid` high, `m_data` is held stable until popped.
- State machine:
  - IDLE: `drain_en`=0 and nothing pending. Goes to RUN when `drain_en`=1.
  - RUN: reads are permitted. Goes to STOP when `drain_en`=0.
  - STOP: no new `rd_en`, but the in-flight word is still captured and buffered words are still presented. Goes to RUN when `drain_en`=1, or to IDLE when `occ`=0 and `inflight`=0.
- `busy = (occ != 0) || inflight`.
- `err_underflow` is set at any edge where `underflow` is sampled high and clears only on reset. Correct operation never sets it.

## Timing
- Reset values (asynchronous, immediate): `rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `word_count`=0, `err_underflow`=0, state IDLE, `occ`=0, `inflight`=0, pointers 0. Buffer contents are 0.
- Reset mid-operation discards any in-flight and buffered words. `data_out` after reset release is ignored unless `inflight` is set.
- `rd_en` rises combinationally in the same cycle `drain_en`=1 and `empty`=0.
- Latency from a sampled read to `m_valid`: the word is captured at edge N+1, so `m_valid` is high after edge N+1 (two edges).
- Throughput: with `m_ready`=1 and the FIFO non-empty, one word per cycle is sustained after the first two cycles.
- Backpressure: with `m_ready`=0, exactly BUF_DEPTH reads are issued, then `rd_en` stays 0. When `m_ready` rises, reading resumes with no lost or duplicated words.
- `empty` rising mid-stream: `rd_en` drops in the same cycle, and the in-flight word is still captured.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0. Assert `rst_n` low asynchronously mid-burst -> outputs clear before the next edge.
- Streaming: preload the FIFO with 0x0001..0x0008, set `drain_en`=1 and `m_ready`=1 -> `m_data` reads 0x0001..0x0008 in order, on 8 consecutive cycles starting 2 edges after the first `rd_en`. `word_count`=8, then `busy`=0 and `rd_en`=0.
- Backpressure: 8 words with `m_ready`=0 -> exactly 3 `rd_en` pulses and `m_valid`=1 holding 0x0001. Toggle `m_ready` 1/0 -> all 8 words are delivered once each, in order, and the FIFO reaches empty.
- Stop mid-drain: drop `drain_en` after the 4th `rd_en` -> no further `rd_en`. Buffered and in-flight words are delivered and the state reaches IDLE. Re-enable -> words 5..8 follow with no gap in sequence.
- Empty boundary: write one word at a time with gaps -> `rd_en` is never high while `empty`=1, and `err_underflow` stays 0. Force `underflow`=1 for one cycle -> `err_underflow`=1 until reset.
- Counter wrap: deliver 65537 words -> `word_count`=1.
